// File: rtl/ecg_pkg.sv
// Shared definitions for the ECG trace buffer: FSM encoding, the mid-scale
// baseline value and the default geometry of the VGA column store.
package ecg_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } ecg_state_t;

    localparam logic [11:0] BASELINE          = 12'h800;
    localparam int          DEFAULT_DEPTH     = 640;
    localparam logic [11:0] DEFAULT_BASE_ADDR = 12'h801;

endpackage

// File: rtl/ecg_trace_buffer_if.sv
// Sample stream, freeze control and display read port of the ECG trace buffer.
interface ecg_trace_buffer_if;

    logic [11:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        freeze;
    logic        frame_sync;
    logic [11:0] rd_addr;
    logic [31:0] rd_data;
    logic [9:0]  wr_col;
    logic        frozen;

    modport master (
        output sample_in, sample_valid, freeze, frame_sync, rd_addr,
        input  sample_ready, rd_data, wr_col, frozen
    );

    modport slave (
        input  sample_in, sample_valid, freeze, frame_sync, rd_addr,
        output sample_ready, rd_data, wr_col, frozen
    );

endinterface

// File: rtl/ecg_col_ram.sv
// Simple dual-port column store: one write port, one registered read port.
// A same-address read and write returns the previous contents.
module ecg_col_ram #(
    parameter int DEPTH = 640,
    parameter int AW    = 10,
    parameter int W     = 12
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ecg_trace_buffer.sv
// Decimating ECG trace store for a VGA display: averages DECIM samples per
// column, supports frame-aligned freeze, and clears to baseline after reset.
module ecg_trace_buffer
    import ecg_pkg::*;
#(
    parameter int          DEPTH     = DEFAULT_DEPTH,
    parameter logic [11:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          DECIM     = 4
) (
    input  logic               clock,
    input  logic               reset,
    ecg_trace_buffer_if.slave  bus
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SHIFT = $clog2(DECIM);

    ecg_state_t  r_state, w_state_next;
    logic [9:0]  r_clr_cnt;
    logic [9:0]  r_wr_col;
    logic [17:0] r_acc;
    logic [6:0]  r_smp_cnt;
    logic        r_rd_vld;
    logic        r_rd_hit;

    logic          w_ready, w_frozen, w_accept, w_avg_done, w_clr_last;
    logic [17:0]   w_sum;
    logic [11:0]   w_col, w_ram_q;
    logic          w_in_range;
    logic          w_we;
    logic [AW-1:0] w_waddr, w_raddr;
    logic [11:0]   w_wdata;

    assign w_accept   = bus.sample_valid && w_ready;
    assign w_sum      = r_acc + {6'd0, bus.sample_in};
    assign w_avg_done = (r_state == ST_RUN) && w_accept && (r_smp_cnt == 7'(DECIM - 1));
    assign w_clr_last = (r_clr_cnt == 10'(DEPTH - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CLEAR:  if (w_clr_last) w_state_next = ST_RUN;
            ST_RUN:    if (bus.frame_sync && bus.freeze) w_state_next = ST_FROZEN;
            ST_FROZEN: if (bus.frame_sync && !bus.freeze) w_state_next = ST_RUN;
            default:   w_state_next = ST_CLEAR;
        endcase
    end

    always_comb begin
        w_ready  = (r_state != ST_CLEAR);
        w_frozen = (r_state == ST_FROZEN);
    end

    // A completing average is written even when this same cycle freezes.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_wr_col[AW-1:0];
        w_wdata = w_sum[SHIFT +: 12];
        if (!reset) begin
            if (r_state == ST_CLEAR) begin
                w_we    = 1'b1;
                w_waddr = r_clr_cnt[AW-1:0];
                w_wdata = BASELINE;
            end else if (w_avg_done) begin
                w_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_wr_col  <= '0;
            r_acc     <= '0;
            r_smp_cnt <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_hit  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rd_vld <= 1'b1;
            r_rd_hit <= w_in_range;
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 10'd1;
            end
            if (w_avg_done) begin
                r_acc     <= '0;
                r_smp_cnt <= '0;
                r_wr_col  <= (r_wr_col == 10'(DEPTH - 1)) ? 10'd0 : r_wr_col + 10'd1;
            end else if (r_state == ST_RUN && w_accept) begin
                r_acc     <= w_sum;
                r_smp_cnt <= r_smp_cnt + 7'd1;
            end else if (r_state == ST_FROZEN && w_state_next == ST_RUN) begin
                r_acc     <= '0;
                r_smp_cnt <= '0;
            end
        end
    end

    assign w_col      = bus.rd_addr - BASE_ADDR;
    assign w_in_range = (w_col < 12'(DEPTH));
    assign w_raddr    = w_in_range ? w_col[AW-1:0] : '0;

    ecg_col_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (12)
    ) u_col_ram (
        .clock   (clock),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_q)
    );

    assign bus.rd_data      = r_rd_vld ? {20'd0, (r_rd_hit ? w_ram_q : BASELINE)} : 32'd0;
    assign bus.sample_ready = w_ready;
    assign bus.frozen       = w_frozen;
    assign bus.wr_col       = r_wr_col;

endmodule

// File: tb/tb_ecg_trace_buffer.sv
// Randomized lockstep check of ecg_trace_buffer against a column/queue model
// of the trace store, plus directed averaging, wrap, freeze and reset cases.
module tb_ecg_trace_buffer;

    localparam int DEPTH = 640;
    localparam int BASE  = 'h801;
    localparam int DECIM = 4;

    logic clock;
    logic reset;
    ecg_trace_buffer_if bus ();

    ecg_trace_buffer #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (12'h801),
        .DECIM     (DECIM)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Model: mode 0=clearing, 1=running, 2=held
    int m_mode = 0;
    int m_clr  = 0;
    int m_col  = 0;
    int m_mem [DEPTH];
    bit m_known [DEPTH];
    int m_q [$];
    int exp_rd = 0;
    bit exp_known = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int c;
        int sum;
        bit acc;
        if (reset) begin
            m_mode = 0; m_clr = 0; m_col = 0;
            m_q.delete();
            exp_rd = 0; exp_known = 1'b1;
            return;
        end
        c = (int'(bus.rd_addr) - BASE) & 'hFFF;
        if (c < DEPTH) begin
            exp_rd = m_mem[c]; exp_known = m_known[c];
        end else begin
            exp_rd = 'h800; exp_known = 1'b1;
        end
        acc = bus.sample_valid && (m_mode != 0);
        case (m_mode)
            0: begin
                m_mem[m_clr] = 'h800; m_known[m_clr] = 1'b1;
                m_clr++;
                if (m_clr == DEPTH) m_mode = 1;
            end
            1: begin
                if (acc) m_q.push_back(int'(bus.sample_in));
                if (m_q.size() == DECIM) begin
                    sum = 0;
                    foreach (m_q[k]) sum += m_q[k];
                    m_mem[m_col] = sum / DECIM; m_known[m_col] = 1'b1;
                    $display("col %0d written %0h", m_col, sum / DECIM);
                    m_col = (m_col + 1) % DEPTH;
                    m_q.delete();
                end
                if (bus.frame_sync && bus.freeze) m_mode = 2;
            end
            default: begin
                if (bus.frame_sync && !bus.freeze) begin
                    m_mode = 1; m_q.delete();
                end
            end
        endcase
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        chk("sample_ready", int'(bus.sample_ready), int'(m_mode != 0));
        chk("frozen", int'(bus.frozen), int'(m_mode == 2));
        chk("wr_col", int'(bus.wr_col), m_col);
        if (exp_known) chk("rd_data", int'(bus.rd_data), exp_rd);
    endtask

    task automatic drive(input bit v, input int s, input bit fz, input bit fs, input int a);
        bus.sample_valid = v;
        bus.sample_in    = 12'(s);
        bus.freeze       = fz;
        bus.frame_sync   = fs;
        bus.rd_addr      = 12'(a);
    endtask

    initial begin
        int r;
        bit fz;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        step(); step();
        chk("reset_rd_data", int'(bus.rd_data), 0);

        // Reset mid-clear restarts from column 0
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 1, 1, $urandom_range(0, 4095));
            step();
        end
        reset = 1'b1; step(); reset = 1'b0;

        // Full clear: ready stays low for exactly DEPTH cycles
        for (int i = 0; i < DEPTH; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 4095), 1, 1, $urandom_range(0, 4095));
            step();
        end
        for (int a = BASE; a < BASE + DEPTH; a++) begin
            drive(0, 0, 0, 0, a);
            step();
        end
        drive(0, 0, 0, 0, BASE); step();
        chk("cleared_col0", int'(bus.rd_data), 'h800);

        // Directed average
        drive(1, 100, 0, 0, 0); step();
        drive(1, 200, 0, 0, 0); step();
        drive(1, 300, 0, 0, 0); step();
        drive(1, 401, 0, 0, 0); step();
        chk("wr_col_after_avg", int'(bus.wr_col), 1);
        drive(0, 0, 0, 0, BASE); step();
        chk("avg_250", int'(bus.rd_data), 250);

        // Randomized traffic with collisions, freeze and frame syncs
        fz = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) fz = ~fz;
            r = $urandom_range(0, 9);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4095), fz,
                  $urandom_range(0, 39) == 0,
                  (r < 3) ? BASE + m_col :
                  (r == 3) ? $urandom_range(0, 4095) : BASE - 2 + $urandom_range(0, DEPTH + 3));
            step();
        end

        // Fill every column with full-scale samples, wrapping wr_col
        drive(0, 0, 0, 1, 0); step();
        for (int i = 0; i < DEPTH * DECIM + DECIM; i++) begin
            drive(1, 'hFFF, 0, 0, BASE - 1 + $urandom_range(0, DEPTH + 1));
            step();
        end
        for (int a = BASE; a < BASE + DEPTH; a++) begin
            drive(0, 0, 0, 0, a);
            step();
            chk("full_scale", int'(bus.rd_data), 'hFFF);
        end
        drive(0, 0, 0, 0, 'h800); step();
        chk("below_range", int'(bus.rd_data), 'h800);
        drive(0, 0, 0, 0, 'hA81); step();
        chk("above_range", int'(bus.rd_data), 'h800);

        // Freeze without frame_sync has no effect; then hold and resume
        for (int i = 0; i < 100; i++) begin
            drive(1, $urandom_range(0, 4095), 1, 0, BASE + m_col); step();
        end
        drive(1, $urandom_range(0, 4095), 1, 1, 0); step();
        chk("frozen_set", int'(bus.frozen), 1);
        for (int i = 0; i < 50; i++) begin
            drive(1, $urandom_range(0, 4095), 1, 0, BASE + m_col); step();
        end
        drive(1, 7, 0, 1, 0); step();
        for (int i = 0; i < DECIM * 3; i++) begin
            drive(1, $urandom_range(0, 4095), 0, 0, BASE + m_col); step();
        end

        // Write three columns, freeze, then reset while held
        for (int i = 0; i < DECIM * 3; i++) begin
            drive(1, $urandom_range(0, 2000), 0, 0, 0); step();
        end
        drive(0, 0, 1, 1, 0); step();
        reset = 1'b1; drive(0, 0, 1, 0, 0); step(); reset = 1'b0;
        chk("reset_frozen", int'(bus.frozen), 0);
        chk("reset_wr_col", int'(bus.wr_col), 0);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 'hFFF, 0, 0, 0); step();
        end
        for (int a = BASE; a < BASE + 3; a++) begin
            drive(0, 0, 0, 0, a); step();
            chk("recleared", int'(bus.rd_data), 'h800);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
